// File: rtl/seg_scan_pkg.sv
// Shared definitions for the seven-segment scan controller.
//   state_t          : scan FSM states (IDLE, BLANK, ON)
//   anode_on_level   : drive level of an asserted anode for a given polarity
//   anode_off_level  : drive level of an inactive anode for a given polarity
//   params_legal     : elaboration-time legality test of the top parameters
package seg_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        ON    = 2'd2
    } state_t;

    localparam int MIN_DIGITS = 2;
    localparam int MAX_DIGITS = 16;

    function automatic logic anode_on_level(input bit active_low);
        return active_low ? 1'b0 : 1'b1;
    endfunction

    function automatic logic anode_off_level(input bit active_low);
        return active_low ? 1'b1 : 1'b0;
    endfunction

    function automatic bit params_legal(input int num_digits,
                                        input int slot_cycles,
                                        input int blank_cycles);
        return (num_digits >= MIN_DIGITS) && (num_digits <= MAX_DIGITS) &&
               (slot_cycles >= 2) && (blank_cycles >= 0) &&
               (blank_cycles < slot_cycles);
    endfunction

endpackage

// File: rtl/seg_scan_next_digit.sv
// Combinational rotate-priority encoder for the digit scan.
//   mask    : per-digit participation mask
//   cur     : index of the digit currently selected
//   nxt     : next set mask bit strictly above cur, else the lowest set bit
//   wrapped : 1 when nxt did not come from above cur (scan wrapped)
//   lowest  : lowest set mask bit (0 when mask is empty)
module seg_scan_next_digit
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int SEL_W      = $clog2(NUM_DIGITS)
) (
    input  logic [NUM_DIGITS-1:0] mask,
    input  logic [SEL_W-1:0]      cur,
    output logic [SEL_W-1:0]      nxt,
    output logic                  wrapped,
    output logic [SEL_W-1:0]      lowest
);

    // Both searches walk downward so the last hit, i.e. the lowest
    // qualifying index, is the one that sticks.
    always_comb begin
        lowest = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (mask[i]) begin
                lowest = SEL_W'(i);
            end
        end

        nxt     = lowest;
        wrapped = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (mask[i] && (i > int'(cur))) begin
                nxt     = SEL_W'(i);
                wrapped = 1'b0;
            end
        end
    end

endmodule

// File: rtl/seg_scan_controller.sv
// Multiplexed seven-segment scan controller with internal slot timer,
// per-digit enable mask, anti-ghosting blanking and frame-start strobe.
//   clk         : system clock
//   reset       : synchronous active-low reset
//   en          : scan enable; 0 turns all anodes off on the next cycle
//   digit_mask  : 1 = digit takes part in the scan
//   anode       : one-hot anode drive, polarity set by ANODE_ACTIVE_LOW
//   S           : index of the digit currently selected
//   blank       : 1 while no anode is asserted
//   frame_start : one-cycle pulse on the first slot of each scan frame
module seg_scan_controller
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS       = 8,
    parameter int SLOT_CYCLES      = 208334,
    parameter int BLANK_CYCLES     = 1000,
    parameter bit ANODE_ACTIVE_LOW = 1'b1,
    parameter int SEL_W            = $clog2(NUM_DIGITS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [NUM_DIGITS-1:0] digit_mask,
    output logic [NUM_DIGITS-1:0] anode,
    output logic [SEL_W-1:0]      S,
    output logic                  blank,
    output logic                  frame_start
);

    localparam int CNT_W = $clog2(SLOT_CYCLES);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST =
        CNT_W'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);
    localparam state_t SLOT_ENTRY = (BLANK_CYCLES == 0) ? ON : BLANK;
    localparam logic   ANODE_ON   = anode_on_level(ANODE_ACTIVE_LOW);
    localparam logic   ANODE_OFF  = anode_off_level(ANODE_ACTIVE_LOW);

    if (!params_legal(NUM_DIGITS, SLOT_CYCLES, BLANK_CYCLES)) begin : g_param_check
        $error("seg_scan_controller: illegal NUM_DIGITS/SLOT_CYCLES/BLANK_CYCLES");
    end

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [SEL_W-1:0]        s_d;
    logic                    fs_d;
    logic [NUM_DIGITS-1:0]   anode_d;
    logic [SEL_W-1:0]        nxt_idx;
    logic [SEL_W-1:0]        low_idx;
    logic                    nxt_wrapped;

    seg_scan_next_digit #(
        .NUM_DIGITS (NUM_DIGITS),
        .SEL_W      (SEL_W)
    ) u_next_digit (
        .mask    (digit_mask),
        .cur     (S),
        .nxt     (nxt_idx),
        .wrapped (nxt_wrapped),
        .lowest  (low_idx)
    );

    // Next-state logic. digit_mask is only consulted on the IDLE exit and at
    // the slot boundary, so a mid-slot mask change never shortens a slot.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        s_d     = S;
        fs_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (en && (digit_mask != '0)) begin
                    s_d     = low_idx;
                    cnt_d   = '0;
                    fs_d    = 1'b1;
                    state_d = SLOT_ENTRY;
                end
            end
            BLANK: begin
                if (!en) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == BLANK_LAST) begin
                        state_d = ON;
                    end
                end
            end
            ON: begin
                if (!en) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == SLOT_LAST) begin
                    cnt_d = '0;
                    if (digit_mask == '0) begin
                        state_d = IDLE;
                    end else begin
                        s_d     = nxt_idx;
                        fs_d    = nxt_wrapped;
                        state_d = SLOT_ENTRY;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they can be registered
    // alongside it; an out-of-range index simply matches no anode.
    always_comb begin
        anode_d = {NUM_DIGITS{ANODE_OFF}};
        if (state_d == ON) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (int'(s_d) == i) begin
                    anode_d[i] = ANODE_ON;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            S           <= '0;
            anode       <= {NUM_DIGITS{ANODE_OFF}};
            blank       <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            S           <= s_d;
            anode       <= anode_d;
            blank       <= (state_d != ON);
            frame_start <= fs_d;
        end
    end

endmodule

// File: tb/tb_seg_scan_controller.sv
// Bench for seg_scan_controller: two instances (BLANK_CYCLES=2 and 0) share
// clk and inputs and are compared every cycle against a slot-position model.
module tb_seg_scan_controller;

    localparam int N     = 4;
    localparam int SLOT  = 10;
    localparam int BLNK  = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic [N-1:0] digit_mask;

    logic [N-1:0] anode_a, anode_b;
    logic [1:0]   s_a, s_b;
    logic         blank_a, blank_b;
    logic         fs_a, fs_b;

    int vectors    = 0;
    int miscompares = 0;

    // Model: scan is either inactive or at position pos (0..SLOT-1) of a
    // slot showing digit d.
    bit active = 1'b0;
    int d      = 0;
    int pos    = 0;
    bit fs     = 1'b0;

    always #5 clk = ~clk;

    seg_scan_controller #(
        .NUM_DIGITS(N), .SLOT_CYCLES(SLOT), .BLANK_CYCLES(BLNK), .ANODE_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .digit_mask(digit_mask),
        .anode(anode_a), .S(s_a), .blank(blank_a), .frame_start(fs_a)
    );

    seg_scan_controller #(
        .NUM_DIGITS(N), .SLOT_CYCLES(SLOT), .BLANK_CYCLES(0), .ANODE_ACTIVE_LOW(1'b1)
    ) dut0 (
        .clk(clk), .reset(reset), .en(en), .digit_mask(digit_mask),
        .anode(anode_b), .S(s_b), .blank(blank_b), .frame_start(fs_b)
    );

    function automatic int lowest_bit(input logic [N-1:0] m);
        for (int i = 0; i < N; i++) if (m[i]) return i;
        return 0;
    endfunction

    function automatic int next_bit(input logic [N-1:0] m, input int cur);
        for (int k = 1; k <= N; k++) if (m[(cur + k) % N]) return (cur + k) % N;
        return cur;
    endfunction

    task automatic model_edge();
        fs = 1'b0;
        if (!reset) begin
            active = 1'b0;
            d      = 0;
            pos    = 0;
        end else if (!active) begin
            if (en && digit_mask != '0) begin
                active = 1'b1;
                d      = lowest_bit(digit_mask);
                pos    = 0;
                fs     = 1'b1;
            end
        end else if (!en) begin
            active = 1'b0;
        end else if (pos == SLOT - 1) begin
            if (digit_mask == '0) begin
                active = 1'b0;
            end else begin
                int nd;
                nd  = next_bit(digit_mask, d);
                fs  = (nd <= d);
                d   = nd;
                pos = 0;
            end
        end else begin
            pos++;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cycle();
        logic [N-1:0] exp_a, exp_b;
        @(posedge clk);
        model_edge();
        #1;
        exp_a = (active && pos >= BLNK) ? ~(N'(1) << d) : '1;
        exp_b = active ? ~(N'(1) << d) : '1;
        chk("anode_b2",  8'(anode_a), 8'(exp_a));
        chk("blank_b2",  8'(blank_a), 8'(!(active && pos >= BLNK)));
        chk("S_b2",      8'(s_a),     8'(d));
        chk("fs_b2",     8'(fs_a),    8'(fs));
        chk("anode_b0",  8'(anode_b), 8'(exp_b));
        chk("blank_b0",  8'(blank_b), 8'(!active));
        chk("S_b0",      8'(s_b),     8'(d));
        chk("fs_b0",     8'(fs_b),    8'(fs));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        // Reset held 3 cycles with scan requested.
        reset = 1'b0; en = 1'b1; digit_mask = 4'b1111;
        run(3);
        // Full scan 0-1-2-3-0.
        reset = 1'b1;
        run(45);
        // Skip pattern.
        digit_mask = 4'b1010;
        run(40);
        // Single enabled digit.
        digit_mask = 4'b0100;
        run(30);
        // Mid-slot disable (a few cycles into ON), then restart.
        digit_mask = 4'b1111;
        run(5);
        en = 1'b0;
        run(3);
        en = 1'b1;
        run(25);
        // Mask shrinks mid-slot while S=1.
        while (!(s_a == 2'd1 && !blank_a)) cycle();
        digit_mask = 4'b0001;
        run(25);
        // Empty mask at a boundary.
        digit_mask = 4'b0000;
        run(15);
        digit_mask = 4'b0110;
        run(16);
        // Reset during ON.
        reset = 1'b0;
        run(1);
        reset = 1'b1;
        run(12);
        // Randomized operation.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 24) == 0) digit_mask = N'($urandom);
            en    = ($urandom_range(0, 39) != 0);
            reset = ($urandom_range(0, 149) != 0);
            cycle();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seg_scan_controller.md
# seg_scan_controller

Parametrised multiplexed seven-segment scan controller. It drives NUM_DIGITS one-hot anodes and a digit-select index S that chooses which digit value the downstream segment mux presents. Compared with the fixed 8-digit controller, it adds:
- an internal slot timer, so no external divided clock is needed;
- a per-digit enable mask, with disabled digits skipped;
- an anti-ghosting blanking interval between digits;
- selectable anode polarity;
- a frame-start strobe.

## Interface
- NUM_DIGITS, 8, number of digits scanned; legal range 2..16
- SLOT_CYCLES, 208334, clk cycles per digit slot (100 MHz / 480 Hz)
- BLANK_CYCLES, 1000, dead-time at the start of each slot with all anodes off; 0 is legal; must be < SLOT_CYCLES
- ANODE_ACTIVE_LOW, 1, 1: asserted anode = 0; 0: asserted anode = 1
- SEL_W, $clog2(NUM_DIGITS), width of S (derived)
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset
- en  input  1  scan enable; 0 forces all anodes off
- digit_mask  input  NUM_DIGITS  1 = digit participates in the scan
- anode  output  NUM_DIGITS  one-hot anode drive (polarity per ANODE_ACTIVE_LOW), registered
- S  output  SEL_W  index of the current digit, registered
- blank  output  1  1 while no anode is asserted (IDLE or BLANK), registered
- frame_start  output  1  one-cycle pulse at the first slot of each scan frame, registered

## Operation
- States: IDLE, BLANK, ON. One slot counter, cnt, with width clog2(SLOT_CYCLES).
- IDLE:
  - all anodes inactive; blank=1.
  - If en=1 and digit_mask≠0: load S with the lowest set mask index, clear cnt, pulse frame_start, go to BLANK (or ON if BLANK_CYCLES=0).
- BLANK:
  - anodes inactive; blank=1; cnt increments.
  - When cnt = BLANK_CYCLES−1: go to ON and assert anode[S].
- ON:
  - anode[S] asserted, all other anodes inactive; blank=0; cnt increments.
  - When cnt = SLOT_CYCLES−1 (slot boundary), the next state is decided as follows:
    - en=0 or digit_mask=0: go to IDLE.
    - Otherwise: S ← next set mask bit strictly above S, wrapping to the lowest set bit. cnt clears and the state goes to BLANK (or ON if BLANK_CYCLES=0). frame_start pulses if the new S ≤ the old S (wrap).
- Single enabled digit: it is reselected every slot and frame_start pulses every slot.
- en deasserted mid-slot: the next cycle enters IDLE with anodes off (no wait for the slot boundary). S holds its value.
- digit_mask sampling:
  - digit_mask is sampled only at the slot boundary and on the IDLE exit.
  - A mid-slot change never truncates the current slot, even if it disables the current digit.
- Out-of-range S (NUM_DIGITS not a power of two) is unreachable; the anode decode defaults to all inactive.

## Timing
- Reset (reset=0 at a clk edge) forces, on that edge:
  - state=IDLE, S=0, cnt=0;
  - anode all inactive (all 1s when ANODE_ACTIVE_LOW=1);
  - blank=1, frame_start=0.
- Reset mid-slot overrides everything and takes effect on the same edge.
- IDLE-exit latency:
  - First edge with reset=1, en=1, mask≠0: S loads and frame_start=1 in the following cycle.
  - anode[S] asserts BLANK_CYCLES cycles later.
- Steady state: each enabled digit is asserted for exactly SLOT_CYCLES−BLANK_CYCLES cycles per slot. Slots are exactly SLOT_CYCLES long.
- Anode timing relative to S: anode asserts no earlier than one cycle after S changes. With BLANK_CYCLES=0, S and anode change on the same edge.
- All outputs come from flops; there are no combinational input-to-output paths.

## Structure
- Shared package seg_scan_pkg holds:
  - state enum (IDLE=2'd0, BLANK=2'd1, ON=2'd2);
  - ANODE_OFF/ANODE_ON polarity helper constants;
  - parameter legality checks (elaboration-time assertions).
- One sub-module: seg_scan_next_digit, a combinational rotate-priority encoder.
  - Inputs: mask, current index.
  - Outputs: next index, wrapped flag.
  - It also supplies the lowest-set-bit index used on the IDLE exit.

## Test plan
All scenarios use NUM_DIGITS=4, SLOT_CYCLES=10, BLANK_CYCLES=2, ANODE_ACTIVE_LOW=1.
- Reset and full scan:
  - Stimulus: hold reset=0 for 3 cycles, then release with en=1, mask=4'b1111.
  - Required: anode=4'b1111 and blank=1 during reset.
  - Required: frame_start pulses once with S=0; anode=4'b1110 after 2 cycles, held for 8 cycles.
  - Required: S steps 0→1→2→3→0 at 10-cycle intervals, with frame_start on each return to 0.
- Skip: mask=4'b1010 → S alternates 1,3,1,3; anode 1101/0111; frame_start on each entry to S=1.
- Single digit: mask=4'b0100 → S=2 every slot; frame_start pulses every 10 cycles; anode low exactly 8 of every 10 cycles.
- Mid-slot disable:
  - en=0 at cycle 5 of an ON slot → next cycle anode=4'b1111, blank=1, state IDLE.
  - Reasserting en restarts from the lowest enabled digit, with frame_start.
- Mask change mid-slot and reset mid-slot:
  - mask goes 1111→0001 while S=1 → the slot completes its 8 ON cycles, then S=0 with a wrap frame_start.
  - reset=0 during ON → IDLE on the same edge.
- BLANK_CYCLES=0 variant: anode and S change on the same edge; no blank cycles appear in the scan.
